// File: rtl/conv_row_ctrl_v2.sv
// conv_row_ctrl_v2: row-stationary convolution sequencer (weights, row sweep, psum accumulate).
// Optional macro CONV_STALL_EN adds psum_ready back-pressure on the COMPUTE state.
module conv_row_ctrl_v2 #(
    parameter int NUM_CHANNEL = 3,
    parameter int IFM_WIDTH   = 9,
    parameter int IFM_HEIGHT  = 9,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    input  logic                   start_conv,
`ifdef CONV_STALL_EN
    input  logic                   psum_ready,
`endif
    output logic                   busy,
    output logic                   wgt_read,
    output logic                   ifm_read,
    output logic [KERNEL_SIZE-1:0] lb_rd_en,
    output logic                   lb_clr,
    output logic                   sel_mux_0,
    output logic                   rd_en_psum,
    output logic                   wr_en_psum,
    output logic                   p_valid_output,
    output logic                   last_channel,
    output logic                   end_conv,
    output logic [7:0]             channel_num,
    output logic [9:0]             collum_num,
    output logic [9:0]             cnt_pixel
);
    localparam int OFM_H = IFM_HEIGHT - KERNEL_SIZE + 1;
    localparam int NWGT  = KERNEL_SIZE * KERNEL_SIZE;
    localparam logic [9:0] PX_WGT = 10'(NWGT - 1);
    localparam logic [9:0] PX_ROW = 10'(IFM_WIDTH - 1);
    localparam logic [9:0] PX_OUT = 10'(KERNEL_SIZE - 1);
    localparam logic [9:0] ROW_L  = 10'(OFM_H - 1);
    localparam logic [7:0] CH_L   = 8'(NUM_CHANNEL - 1);

    typedef enum logic [2:0] {IDLE, LOAD_WGT, COMPUTE, END_ROW, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  ch_q, ch_d;
    logic [9:0]  row_q, row_d, px_q, px_d;
    logic        busy_q, busy_d, wgt_q, wgt_d, ifm_q, ifm_d, clr_q, clr_d;
    logic        sel_q, sel_d, rd_q, rd_d, wr_q, wr_d, pv_q, pv_d;
    logic        last_q, last_d, end_q, end_d, oc_d, stall;

`ifdef CONV_STALL_EN
    assign stall = (state_q == COMPUTE) && !psum_ready;
`else
    assign stall = 1'b0;
`endif

    // Next-state/counter sequencing, then Moore decode of the next state for the output flops
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        row_d   = row_q;
        px_d    = px_q;
        case (state_q)
            IDLE: if (start_conv) begin
                state_d = LOAD_WGT;
                ch_d    = '0;
                row_d   = '0;
                px_d    = '0;
            end
            LOAD_WGT: begin
                state_d = (px_q == PX_WGT) ? COMPUTE : LOAD_WGT;
                px_d    = (px_q == PX_WGT) ? '0 : px_q + 10'd1;
            end
            COMPUTE: if (!stall) begin
                state_d = (px_q == PX_ROW) ? END_ROW : COMPUTE;
                px_d    = (px_q == PX_ROW) ? '0 : px_q + 10'd1;
            end
            END_ROW: begin
                px_d    = '0;
                state_d = (row_q != ROW_L) ? COMPUTE : (ch_q != CH_L) ? LOAD_WGT : DONE;
                row_d   = (row_q != ROW_L) ? row_q + 10'd1 : '0;
                ch_d    = (row_q != ROW_L) ? ch_q : (ch_q != CH_L) ? ch_q + 8'd1 : '0;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD_WGT) || (state_d == COMPUTE) || (state_d == END_ROW);
        wgt_d  = (state_d == LOAD_WGT);
        ifm_d  = (state_d == COMPUTE);
        clr_d  = (state_d == END_ROW);
        end_d  = (state_d == DONE);
        oc_d   = ifm_d && (px_d >= PX_OUT);
        last_d = busy_d && (ch_d == CH_L);
        wr_d   = oc_d;
        rd_d   = oc_d && (ch_d != 8'd0);
        sel_d  = oc_d && (ch_d == 8'd0);
        pv_d   = oc_d && last_d;
    end

    // State, counters and registered outputs with synchronous active-low reset
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            row_q   <= '0;
            px_q    <= '0;
            busy_q  <= 1'b0;
            wgt_q   <= 1'b0;
            ifm_q   <= 1'b0;
            clr_q   <= 1'b0;
            sel_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            pv_q    <= 1'b0;
            last_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            row_q   <= row_d;
            px_q    <= px_d;
            busy_q  <= busy_d;
            wgt_q   <= wgt_d;
            ifm_q   <= ifm_d;
            clr_q   <= clr_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            pv_q    <= pv_d;
            last_q  <= last_d;
            end_q   <= end_d;
        end
    end

    assign busy           = busy_q;
    assign wgt_read       = wgt_q;
    assign ifm_read       = ifm_q & ~stall;
    assign lb_rd_en       = {KERNEL_SIZE{ifm_q & ~stall}};
    assign lb_clr         = clr_q;
    assign sel_mux_0      = sel_q & ~stall;
    assign rd_en_psum     = rd_q & ~stall;
    assign wr_en_psum     = wr_q & ~stall;
    assign p_valid_output = pv_q & ~stall;
    assign last_channel   = last_q;
    assign end_conv       = end_q;
    assign channel_num    = ch_q;
    assign collum_num     = row_q;
    assign cnt_pixel      = px_q;
endmodule

// File: tb/tb_conv_row_ctrl_v2.sv
// tb_conv_row_ctrl_v2: vector table plus psum-write scoreboard for the convolution sequencer.
module tb_conv_row_ctrl_v2;
    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic rst_n, start0, start1;
`ifdef CONV_STALL_EN
    logic psum_ready = 1'b1;
`endif
    logic busy, wgt_read, ifm_read, lb_clr, sel_mux_0, rd_en_psum, wr_en_psum;
    logic p_valid_output, last_channel, end_conv;
    logic [2:0] lb_rd_en;
    logic [7:0] channel_num;
    logic [9:0] collum_num, cnt_pixel;
    logic d1_busy, d1_wgt, d1_ifm, d1_clr, d1_sel, d1_rd, d1_wr, d1_pv, d1_last, d1_end;
    logic [0:0] d1_lb;
    logic [7:0] d1_ch;
    logic [9:0] d1_row, d1_px;

    conv_row_ctrl_v2 dut0 (
        .clk1(clk1), .rst_n(rst_n), .start_conv(start0),
`ifdef CONV_STALL_EN
        .psum_ready(psum_ready),
`endif
        .busy(busy), .wgt_read(wgt_read), .ifm_read(ifm_read), .lb_rd_en(lb_rd_en),
        .lb_clr(lb_clr), .sel_mux_0(sel_mux_0), .rd_en_psum(rd_en_psum),
        .wr_en_psum(wr_en_psum), .p_valid_output(p_valid_output),
        .last_channel(last_channel), .end_conv(end_conv), .channel_num(channel_num),
        .collum_num(collum_num), .cnt_pixel(cnt_pixel)
    );

    conv_row_ctrl_v2 #(.NUM_CHANNEL(1), .IFM_WIDTH(4), .IFM_HEIGHT(4), .KERNEL_SIZE(1)) dut1 (
        .clk1(clk1), .rst_n(rst_n), .start_conv(start1),
`ifdef CONV_STALL_EN
        .psum_ready(psum_ready),
`endif
        .busy(d1_busy), .wgt_read(d1_wgt), .ifm_read(d1_ifm), .lb_rd_en(d1_lb),
        .lb_clr(d1_clr), .sel_mux_0(d1_sel), .rd_en_psum(d1_rd),
        .wr_en_psum(d1_wr), .p_valid_output(d1_pv),
        .last_channel(d1_last), .end_conv(d1_end), .channel_num(d1_ch),
        .collum_num(d1_row), .cnt_pixel(d1_px)
    );

    // flags: busy wgt ifm clr end wr rd sel pv last
    typedef struct {int t; logic [9:0] f; int px; int ch; int row;} vec_t;
    typedef struct {int ch; int row; int px; logic rd; logic sel; logic pv;} sb_t;
    vec_t vt[16];
    sb_t  q[$];
    int tests = 0, fails = 0;
    int pv_n = 0, wgt_n = 0, pv1_n = 0, rd1_n = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        sb_t e;
        @(negedge clk1);
        if (wr_en_psum) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_extra: unexpected wr_en_psum at ch %0d row %0d px %0d", channel_num, collum_num, cnt_pixel);
            end else begin
                e = q.pop_front();
                chk("sb_pix", {channel_num, collum_num, cnt_pixel, rd_en_psum, sel_mux_0, p_valid_output},
                    {8'(e.ch), 10'(e.row), 10'(e.px), e.rd, e.sel, e.pv});
            end
        end
        if (p_valid_output) pv_n++;
        if (wgt_read) wgt_n++;
        if (d1_pv) pv1_n++;
        if (d1_rd) rd1_n++;
    endtask

    task automatic push_run();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 7; r++)
                for (int p = 2; p < 9; p++)
                    q.push_back('{c, r, p, c != 0, c == 0, c == 2});
    endtask

    function automatic logic [9:0] flags0();
        return {busy, wgt_read, ifm_read, lb_clr, end_conv, wr_en_psum, rd_en_psum,
                sel_mux_0, p_valid_output, last_channel};
    endfunction

    task automatic run_default();
        int vi = 0;
        int pv0 = pv_n, w0 = wgt_n;
        push_run();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int t = 0; t <= 238; t++) begin
            if (vi < 16 && vt[vi].t == t) begin
                chk($sformatf("vec_t%0d", t),
                    {flags0(), lb_rd_en, cnt_pixel, channel_num, collum_num},
                    {vt[vi].f, {3{vt[vi].f[7]}}, 10'(vt[vi].px), 8'(vt[vi].ch), 10'(vt[vi].row)});
                vi++;
            end
            if (t == 50 || t == 237) start0 = 1'b1;
            if (t == 51 || t == 238) start0 = 1'b0;
            tick();
        end
        chk("sb_left", 64'(q.size()), 0);
        chk("pv_total", 64'(pv_n - pv0), 49);
        chk("wgt_total", 64'(wgt_n - w0), 27);
    endtask

    initial begin
        vt[0]  = '{0,   10'b1100000000, 0, 0, 0};
        vt[1]  = '{8,   10'b1100000000, 8, 0, 0};
        vt[2]  = '{9,   10'b1010000000, 0, 0, 0};
        vt[3]  = '{10,  10'b1010000000, 1, 0, 0};
        vt[4]  = '{11,  10'b1010010100, 2, 0, 0};
        vt[5]  = '{17,  10'b1010010100, 8, 0, 0};
        vt[6]  = '{18,  10'b1001000000, 0, 0, 0};
        vt[7]  = '{19,  10'b1010000000, 0, 0, 1};
        vt[8]  = '{78,  10'b1001000000, 0, 0, 6};
        vt[9]  = '{79,  10'b1100000000, 0, 1, 0};
        vt[10] = '{90,  10'b1010011000, 2, 1, 0};
        vt[11] = '{158, 10'b1100000001, 0, 2, 0};
        vt[12] = '{169, 10'b1010011011, 2, 2, 0};
        vt[13] = '{236, 10'b1001000001, 0, 2, 6};
        vt[14] = '{237, 10'b0000100000, 0, 0, 0};
        vt[15] = '{238, 10'b0000000000, 0, 0, 0};

        rst_n = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        tick();
        tick();
        chk("reset_dut0", {flags0(), lb_rd_en, cnt_pixel, channel_num, collum_num}, 0);
        chk("reset_dut1", {d1_busy, d1_wgt, d1_ifm, d1_pv, d1_last, d1_end, d1_lb}, 0);
        rst_n = 1'b1;
        tick();

        run_default();

        // Mid-run reset during channel 1 compute, then a fresh full run from channel 0
        begin
            push_run();
            start0 = 1'b1;
            tick();
            start0 = 1'b0;
            for (int t = 0; t < 91; t++) tick();
            chk("pre_rst_pos", {channel_num, cnt_pixel, ifm_read}, {8'd1, 10'd3, 1'b1});
            rst_n = 1'b0;
            tick();
            chk("mid_reset", {flags0(), lb_rd_en, cnt_pixel, channel_num, collum_num}, 0);
            rst_n = 1'b1;
            q.delete();
            tick();
            chk("post_reset_idle", {busy, wgt_read}, 0);
            run_default();
        end

        // Single channel, 1x1 kernel, 4x4 map
        begin
            int te = -1;
            int p0 = pv1_n, r0 = rd1_n;
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            for (int t = 0; t < 60; t++) begin
                if (d1_end && te < 0) te = t;
                tick();
            end
            chk("d1_end_t", 64'(te), 21);
            chk("d1_pv_total", 64'(pv1_n - p0), 16);
            chk("d1_rd_total", 64'(rd1_n - r0), 0);
        end

`ifdef CONV_STALL_EN
        // Back-pressure for 5 cycles at cnt_pixel=4 of the first row
        begin
            int te = -1;
            push_run();
            start0 = 1'b1;
            tick();
            start0 = 1'b0;
            for (int t = 0; t < 13; t++) tick();
            chk("stall_pos", cnt_pixel, 4);
            psum_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("stall_hold", {cnt_pixel, ifm_read, wr_en_psum, lb_rd_en}, {10'd4, 1'b0, 1'b0, 3'b000});
            end
            psum_ready = 1'b1;
            for (int t = 18; t < 400; t++) begin
                if (end_conv && te < 0) te = t;
                tick();
            end
            chk("stall_end_t", 64'(te), 242);
            chk("stall_sb_left", 64'(q.size()), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
